pixel_usb_streamer: RTL and testbench
=====================================

Name: pixel_usb_streamer

Overview:
- Downstream consumer of the CCD readout stage's 16-bit pixel stream (data_out / data_avail / data_accept).
- Buffers pixels in a small FIFO and serialises each one to an FT245-style 8-bit asynchronous USB FIFO, MSB byte first.
- Decouples CCD line timing from host USB backpressure.
- Readout stalls only when this block's FIFO is full.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W pixels (16).
- WR_LOW_CYC, 2, clk cycles usb_wr_n is held low per byte (1..15).
- WR_HIGH_CYC, 2, minimum clk cycles usb_wr_n is held high between bytes (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_data  in  16  pixel from readout stage (its data_out).
- pix_avail  in  1  pixel valid; may stay high for several clk cycles per pixel.
- pix_accept  out  1  one-clk pulse accepting the current pixel (to readout data_accept).
- frame_start  in  1  one-clk pulse at readout start; used only with the header feature.
- usb_txe_n  in  1  low = USB FIFO can take a byte; asynchronous, double-flopped internally.
- usb_wr_n  out  1  USB write strobe; byte is latched on the rising edge.
- usb_data  out  8  byte to USB FIFO.
- fifo_level  out  ADDR_W+1  pixels currently buffered.
- overflow  out  1  sticky; set when a pixel is lost. Cleared only by rst.

Behaviour:
- Reset values: pix_accept=0, usb_wr_n=1, usb_data=0, fifo_level=0, overflow=0. FSM goes to S_IDLE. FIFO pointers clear. Synchroniser flops reset to 1 (not ready).
- Input side:
  - avail_rise = pix_avail & ~pix_avail_q.
  - On avail_rise with FIFO not full: write pix_data and assert pix_accept on the same cycle (0-cycle latency from the edge, registered output the next cycle is NOT allowed). pix_accept is combinational from avail_rise & ~full.
  - At most one write per pix_avail high period.
  - On avail_rise with FIFO full: no accept and no write. Retry every cycle while pix_avail stays high and FIFO is still not accepted. Readout stalls in its h8 state.
  - overflow is set only if pix_avail falls without the pixel having been accepted.
- Output FSM, states S_IDLE, S_SETUP, S_STROBE, S_HOLD:
  - S_IDLE: if FIFO not empty and txe_sync==0, pop the pixel into shift reg {msb,lsb}. Drive usb_data=msb. Go to S_SETUP.
  - S_SETUP (1 cycle): data is stable. Go to S_STROBE.
  - S_STROBE: usb_wr_n=0 for WR_LOW_CYC cycles. Go to S_HOLD.
  - S_HOLD: usb_wr_n=1 for WR_HIGH_CYC cycles. Then:
    - if the LSB is pending and txe_sync==0: usb_data=lsb, go to S_SETUP;
    - if the LSB is pending and txe_sync==1: wait in S_HOLD;
    - otherwise go to S_IDLE.
  - usb_data holds its value during wr_n low and for 1 cycle after the rising edge.
- Simultaneous push and pop: both occur; fifo_level is unchanged.
- Empty FIFO: usb_wr_n stays 1.
- Pointers wrap modulo depth. Full/empty use the extra MSB of fifo_level.
- rst mid-byte: usb_wr_n returns to 1 the next cycle and the partial pixel is discarded.

Optional Feature:
- Macro: PIXEL_USB_HEADER_EN.
- Enabled: on frame_start, a 4-byte header is queued ahead of the next pixel: 0xA5, 0x5A, frame_cnt[15:8], frame_cnt[7:0].
  - frame_cnt is 16 bits, reset 0, incremented after the header is sent, wraps at 0xFFFF.
  - Header bytes use the same strobe timing.
  - A frame_start arriving while a header is pending is ignored.
  - Pixels arriving during the header are buffered normally.
- Disabled: frame_start is ignored. No counter logic exists.

Decomposition:
- Shared package pixel_usb_pkg:
  - FSM state encoding.
  - HDR_MAGIC0=8'hA5, HDR_MAGIC1=8'h5A.
  - Header length 4.
- Sub-module: pixel_fifo_sync, a parameterised single-clock FIFO with 16-bit data, push/pop, full/empty/level.

Test Plan:
- Single pixel: pix_data=16'h1234, pix_avail high 6 cycles, txe_n=0 -> exactly one pix_accept pulse; usb_data 0x12 then 0x34, each under a 2-cycle wr_n low; fifo_level returns to 0.
- Backpressure: txe_n=1, push 16 pixels 0x0000..0x000F -> fifo_level=16. A 17th pixel held high is not accepted while full. Release txe_n -> 17th accepted once space frees; 34 bytes emerge in order; overflow=0.
- Lost pixel: FIFO full, pix_avail high 3 cycles then low -> overflow=1 and stays 1 until rst.
- txe_n toggles between MSB and LSB: pixel 0xBEEF with txe_n=1 after byte 0xBE -> FSM waits in S_HOLD, then emits 0xEF; no extra strobes.
- Reset mid-strobe: rst during S_STROBE -> next cycle usb_wr_n=1, fifo_level=0, pix_accept=0.
- With PIXEL_USB_HEADER_EN: two frame_start pulses, each followed by 1 pixel 0x0102 -> byte stream A5 5A 00 00 01 02 A5 5A 00 01 01 02.

Source files
------------

// File: rtl/pixel_usb_streamer_pkg.sv
// pixel_usb_pkg
//   Shared definitions for the pixel-to-USB streamer: output FSM state
//   encoding, frame header magic bytes and length, and a helper that picks
//   one header byte by index.
//   No ports (package).
package pixel_usb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] HDR_MAGIC0 = 8'hA5;
  localparam logic [7:0] HDR_MAGIC1 = 8'h5A;
  localparam int         HDR_LEN    = 4;

  // Header layout: magic0, magic1, frame counter MSB, frame counter LSB.
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] frame_cnt);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0:    b = HDR_MAGIC0;
      2'd1:    b = HDR_MAGIC1;
      2'd2:    b = frame_cnt[15:8];
      default: b = frame_cnt[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pixel_usb_streamer_if.sv
// pixel_usb_streamer_if
//   Pixel stream handshake between the CCD readout stage and the USB
//   streamer.
//   Signals:
//     pix_data   [15:0] pixel word from the readout stage
//     pix_avail         pixel valid, may stay high for several cycles
//     pix_accept        one-cycle accept pulse back to the readout stage
//   Modports:
//     master  readout side (drives data/avail, receives accept)
//     slave   streamer side (receives data/avail, drives accept)
interface pixel_usb_streamer_if;
  import pixel_usb_pkg::*;

  logic [15:0] pix_data;
  logic        pix_avail;
  logic        pix_accept;

  modport master (output pix_data, output pix_avail, input pix_accept);
  modport slave  (input pix_data, input pix_avail, output pix_accept);

endinterface

// File: rtl/pixel_fifo_sync.sv
// pixel_fifo_sync
//   Single-clock FIFO with first-word-fall-through read data.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     push, din        write request and data (ignored when full)
//     pop              read request (ignored when empty)
//     dout             word at the head of the FIFO
//     full, empty      status flags
//     level            number of words stored (ADDR_W+1 bits)
module pixel_fifo_sync #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers carry one extra bit so a full FIFO is distinguishable from an
  // empty one; the low bits wrap modulo the depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = level[ADDR_W];
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/pixel_usb_streamer.sv
// pixel_usb_streamer
//   Buffers 16-bit pixels from the CCD readout stage and writes each one to
//   an FT245-style 8-bit asynchronous USB FIFO, MSB byte first.
//   Optional frame header (0xA5 0x5A cnt_hi cnt_lo) enabled by defining
//   PIXEL_USB_HEADER_EN; without it frame_start is ignored.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     pix           pixel stream (slave modport: data/avail in, accept out)
//     frame_start   one-cycle pulse at readout start (header feature only)
//     usb_txe_n     low = USB FIFO has room; asynchronous
//     usb_wr_n      USB write strobe, byte latched on its rising edge
//     usb_data      byte to the USB FIFO
//     fifo_level    pixels currently buffered
//     overflow      sticky lost-pixel flag
module pixel_usb_streamer
  import pixel_usb_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pixel_usb_streamer_if.slave  pix,
  input  logic                 frame_start,
  input  logic                 usb_txe_n,
  output logic                 usb_wr_n,
  output logic [7:0]           usb_data,
  output logic [ADDR_W:0]      fifo_level,
  output logic                 overflow
);

  logic        pix_avail_q;
  logic        taken;
  logic        want;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [15:0] fifo_dout;

  logic        txe_meta;
  logic        txe_sync;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [7:0]  data_q;
  logic [7:0]  data_n;
  logic [7:0]  lsb_q;
  logic [7:0]  lsb_n;
  logic [1:0]  rem_q;
  logic [1:0]  rem_n;
  logic        wr_n_q;

  logic        hdr_req;
  logic        hdr_active;
  logic [7:0]  hdr_next;

  pixel_fifo_sync #(.ADDR_W(ADDR_W), .DATA_W(16)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pix.pix_accept),
    .din   (pix.pix_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // 'taken' remembers that the current avail-high period was already
  // accepted, so want covers both the rising edge and the retry-while-full
  // case with a single term and never writes twice per period.
  assign want           = pix.pix_avail & ~taken;
  assign pix.pix_accept = want & ~fifo_full & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_avail_q <= 1'b0;
      taken       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pix_avail_q <= pix.pix_avail;
      taken       <= pix.pix_avail & (taken | pix.pix_accept);
      if (pix_avail_q & ~pix.pix_avail & ~taken) overflow <= 1'b1;
    end
  end

  // Output FSM registers plus the txe_n synchroniser. usb_wr_n is
  // registered from the next state so the strobe is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      data_q   <= 8'h00;
      lsb_q    <= 8'h00;
      rem_q    <= 2'd0;
      wr_n_q   <= 1'b1;
      txe_meta <= 1'b1;
      txe_sync <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      data_q   <= data_n;
      lsb_q    <= lsb_n;
      rem_q    <= rem_n;
      wr_n_q   <= (state_n != S_STROBE);
      txe_meta <= usb_txe_n;
      txe_sync <= txe_meta;
    end
  end

  // rem_q counts bytes still to send after the one currently on usb_data;
  // a pixel has one more (its LSB), a header has three more.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    data_n   = data_q;
    lsb_n    = lsb_q;
    rem_n    = rem_q;
    fifo_pop = 1'b0;
    case (state)
      S_IDLE: begin
        if (!txe_sync) begin
          if (hdr_req) begin
            data_n  = HDR_MAGIC0;
            rem_n   = 2'(HDR_LEN - 1);
            state_n = S_SETUP;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_n   = fifo_dout[15:8];
            lsb_n    = fifo_dout[7:0];
            rem_n    = 2'd1;
            state_n  = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        state_n = S_STROBE;
        cnt_n   = 4'(WR_LOW_CYC - 1);
      end
      S_STROBE: begin
        if (cnt == 4'd0) begin
          state_n = S_HOLD;
          cnt_n   = 4'(WR_HIGH_CYC - 1);
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else if (rem_q != 2'd0) begin
          if (!txe_sync) begin
            data_n  = hdr_active ? hdr_next : lsb_q;
            rem_n   = rem_q - 2'd1;
            state_n = S_SETUP;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef PIXEL_USB_HEADER_EN
  logic        hdr_pending;
  logic [1:0]  hdr_idx;
  logic [15:0] frame_cnt;

  // hdr_pending stays set until the last header byte is strobed, which is
  // what makes a second frame_start during a pending header a no-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_pending <= 1'b0;
      hdr_active  <= 1'b0;
      hdr_idx     <= 2'd0;
      frame_cnt   <= 16'd0;
    end else begin
      if (state == S_IDLE && state_n == S_SETUP && hdr_req) begin
        hdr_active <= 1'b1;
        hdr_idx    <= 2'd0;
      end else if (hdr_active && state == S_HOLD && state_n == S_SETUP) begin
        hdr_idx <= hdr_idx + 2'd1;
      end else if (hdr_active && state == S_HOLD && state_n == S_IDLE) begin
        hdr_active  <= 1'b0;
        hdr_pending <= 1'b0;
        frame_cnt   <= frame_cnt + 16'd1;
      end
      if (frame_start && !hdr_pending) hdr_pending <= 1'b1;
    end
  end

  assign hdr_req  = hdr_pending;
  assign hdr_next = hdr_byte(hdr_idx + 2'd1, frame_cnt);
`else
  logic frame_start_unused;

  assign hdr_req            = 1'b0;
  assign hdr_active         = 1'b0;
  assign hdr_next           = 8'h00;
  assign frame_start_unused = frame_start;
`endif

  assign usb_wr_n = wr_n_q;
  assign usb_data = data_q;

endmodule

// File: tb/tb_pixel_usb_streamer.sv
// tb_pixel_usb_streamer
//   Directed bench for pixel_usb_streamer. Expected USB bytes are queued as
//   pixels are issued; a monitor pops and compares each byte at the rising
//   edge of usb_wr_n. Status outputs are checked directly.
module tb_pixel_usb_streamer;

  localparam int ADDR_W     = 4;
  localparam int WR_LOW_CYC = 2;

  logic            clk;
  logic            rst;
  logic            frame_start;
  logic            usb_txe_n;
  logic            usb_wr_n;
  logic [7:0]      usb_data;
  logic [ADDR_W:0] fifo_level;
  logic            overflow;

  pixel_usb_streamer_if pix_if();

  pixel_usb_streamer #(.ADDR_W(ADDR_W), .WR_LOW_CYC(WR_LOW_CYC), .WR_HIGH_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix         (pix_if),
    .frame_start (frame_start),
    .usb_txe_n   (usb_txe_n),
    .usb_wr_n    (usb_wr_n),
    .usb_data    (usb_data),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  int         n_compared;
  int         n_mismatched;
  int         n_bytes;
  logic [7:0] exp_q[$];
  logic       mon_prev_wr_n;
  int         mon_low_len;
  logic [7:0] mon_low_data;
  logic [7:0] mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: a byte is taken on the wr_n rising edge; it must
  // match the queue head, have been stable through the strobe, and the
  // strobe must be exactly WR_LOW_CYC cycles long.
  initial begin
    mon_prev_wr_n = 1'b1;
    mon_low_len   = 0;
    mon_low_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_wr_n = 1'b1;
        mon_low_len   = 0;
      end else begin
        if (!usb_wr_n) begin
          if (mon_low_len == 0) mon_low_data = usb_data;
          mon_low_len++;
        end else if (!mon_prev_wr_n) begin
          n_bytes++;
          if (exp_q.size() == 0) begin
            check_output("unexpected_byte", {24'd0, usb_data}, 32'hFFFF_FFFF);
          end else begin
            mon_exp = exp_q.pop_front();
            check_output("usb_byte", {24'd0, usb_data}, {24'd0, mon_exp});
            check_output("usb_byte_stable", {24'd0, mon_low_data}, {24'd0, mon_exp});
            check_output("wr_low_cycles", mon_low_len, WR_LOW_CYC);
          end
          mon_low_len = 0;
        end
        mon_prev_wr_n = usb_wr_n;
      end
    end
  end

  task automatic push_pixel_bytes(input logic [15:0] d);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  // Holds pix_avail for 'hold' cycles, then one low cycle. Entered and
  // left just after a rising clock edge.
  task automatic apply_stimulus(input logic [15:0] d, input int hold, output int accepts);
    accepts            = 0;
    pix_if.pix_data    = d;
    pix_if.pix_avail   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (pix_if.pix_accept) accepts++;
      @(posedge clk); #1;
    end
    pix_if.pix_avail = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    pix_if.pix_avail = 1'b0;
    frame_start      = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_wr_n", usb_wr_n, 1);
    check_output("rst_usb_data", usb_data, 0);
    check_output("rst_level", fifo_level, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_accept", pix_if.pix_accept, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || fifo_level != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_output("drain_complete", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int n_acc;
    int base;
    int lows;
    n_compared       = 0;
    n_mismatched     = 0;
    n_bytes          = 0;
    rst              = 1'b1;
    frame_start      = 1'b0;
    usb_txe_n        = 1'b1;
    pix_if.pix_avail = 1'b0;
    pix_if.pix_data  = 16'h0000;
    do_reset();

    $display("[TB] single pixel");
    usb_txe_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    push_pixel_bytes(16'h1234);
    apply_stimulus(16'h1234, 6, acc);
    check_output("single_accepts", acc, 1);
    wait_drain(200);
    check_output("single_level", fifo_level, 0);

    $display("[TB] backpressure");
    usb_txe_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      push_pixel_bytes(16'(i));
      apply_stimulus(16'(i), 2, acc);
      n_acc += acc;
    end
    check_output("fill_accepts", n_acc, 16);
    @(negedge clk);
    check_output("full_level", fifo_level, 16);
    @(posedge clk); #1;
    push_pixel_bytes(16'h0010);
    acc              = 0;
    pix_if.pix_data  = 16'h0010;
    pix_if.pix_avail = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pix_if.pix_accept) acc++;
      @(posedge clk); #1;
    end
    check_output("accept_while_full", acc, 0);
    usb_txe_n = 1'b0;
    for (int i = 0; i < 60 && acc == 0; i++) begin
      @(negedge clk);
      if (pix_if.pix_accept) acc++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pix_if.pix_accept) acc++;
      @(posedge clk); #1;
    end
    pix_if.pix_avail = 1'b0;
    check_output("accept_after_space", acc, 1);
    wait_drain(1000);
    check_output("bp_overflow", overflow, 0);

    $display("[TB] lost pixel");
    usb_txe_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      push_pixel_bytes(16'h0100 + 16'(i));
      apply_stimulus(16'h0100 + 16'(i), 2, acc);
    end
    apply_stimulus(16'hDEAD, 3, acc);
    check_output("lost_accepts", acc, 0);
    @(negedge clk);
    check_output("lost_overflow", overflow, 1);
    @(posedge clk); #1;
    usb_txe_n = 1'b0;
    wait_drain(1000);
    check_output("overflow_sticky", overflow, 1);
    do_reset();

    $display("[TB] txe_n between bytes");
    usb_txe_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    base = n_bytes;
    push_pixel_bytes(16'hBEEF);
    apply_stimulus(16'hBEEF, 2, acc);
    for (int i = 0; i < 20 && usb_wr_n; i++) @(negedge clk);
    check_output("msb_strobe_seen", usb_wr_n, 0);
    usb_txe_n = 1'b1;
    for (int i = 0; i < 20 && n_bytes == base; i++) @(posedge clk);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!usb_wr_n) lows++;
    end
    check_output("hold_no_strobe", lows, 0);
    check_output("hold_bytes", n_bytes - base, 1);
    @(posedge clk); #1;
    usb_txe_n = 1'b0;
    wait_drain(200);
    check_output("toggle_bytes", n_bytes - base, 2);

    $display("[TB] reset mid-strobe");
    usb_txe_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    apply_stimulus(16'h5566, 2, acc);
    apply_stimulus(16'h7788, 2, acc);
    @(negedge clk);
    check_output("pre_reset_level", fifo_level, 2);
    @(posedge clk); #1;
    usb_txe_n = 1'b0;
    for (int i = 0; i < 20 && usb_wr_n; i++) @(negedge clk);
    check_output("strobe_before_reset", usb_wr_n, 0);
    base = n_bytes;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_wr_n", usb_wr_n, 1);
    check_output("midrst_level", fifo_level, 0);
    check_output("midrst_accept", pix_if.pix_accept, 0);
    repeat (30) @(negedge clk);
    check_output("midrst_no_bytes", n_bytes - base, 0);
    @(posedge clk); #1;

`ifdef PIXEL_USB_HEADER_EN
    $display("[TB] frame header");
    do_reset();
    usb_txe_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(f));
      push_pixel_bytes(16'h0102);
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      apply_stimulus(16'h0102, 2, acc);
      check_output("hdr_pixel_accept", acc, 1);
      wait_drain(300);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
